// File: rtl/exp_result_buffer.sv
// exp_result_buffer: FWFT FIFO that converts unsigned Q7.25 exp results to saturated Q4.12
module exp_result_buffer #(
  parameter int WIDTHIN = 32,
  parameter int WIDTHOUT = 16,
  parameter int DEPTH = 16,
  parameter int AW = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                s_valid,
  input  logic [WIDTHIN-1:0]  s_data,
  output logic                s_ready,
  output logic                m_valid,
  output logic [WIDTHOUT-1:0] m_data,
  input  logic                m_ready,
  output logic [AW:0]         level,
  output logic [15:0]         sat_count,
  output logic                err_drop
);
  logic [WIDTHOUT-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic wr, rd, sat;
  logic [WIDTHOUT-1:0] conv;
  always_comb begin
    s_ready = level != (AW+1)'(DEPTH);
    m_valid = level != '0;
    m_data = mem[rd_ptr[AW-1:0]];
    wr = s_valid && s_ready;
    rd = m_valid && m_ready;
    sat = |s_data[WIDTHIN-1:WIDTHIN-3];
    conv = sat ? '1 : s_data[WIDTHIN-4 -: WIDTHOUT];
  end
  // storage carries no reset; stale entries are unreachable once level is cleared
  always_ff @(posedge clk)
    if (wr) mem[wr_ptr[AW-1:0]] <= conv;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      sat_count <= '0;
      err_drop <= 1'b0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (rd) rd_ptr <= rd_ptr + 1'b1;
      if (wr && !rd) level <= level + 1'b1;
      else if (rd && !wr) level <= level - 1'b1;
      if (wr && sat && sat_count != 16'hFFFF) sat_count <= sat_count + 1'b1;
      if (s_valid && !s_ready) err_drop <= 1'b1;
    end
endmodule

// File: tb/tb_exp_result_buffer.sv
// tb_exp_result_buffer: directed and random checks against a queue-based reference model
module tb_exp_result_buffer;
  logic clk = 0, reset = 1, s_valid = 0, m_ready = 0;
  logic [31:0] s_data = 0;
  logic s_ready, m_valid, err_drop;
  logic [15:0] m_data, sat_count;
  logic [4:0] level;
  int total = 0, bad = 0;
  logic [15:0] q[$];
  int m_sat = 0;
  bit m_err = 0;
  exp_result_buffer dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready), .level(level),
    .sat_count(sat_count), .err_drop(err_drop)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [15:0] to_q412(input logic [31:0] x);
    return x >= 32'h2000_0000 ? 16'hFFFF : 16'((x >> 13) & 32'hFFFF);
  endfunction
  task automatic cyc();
    bit w, r, full;
    @(negedge clk);
    chk("level", 32'(level), q.size());
    chk("m_valid", 32'(m_valid), 32'(q.size() != 0));
    chk("s_ready", 32'(s_ready), 32'(q.size() < 16));
    chk("sat_count", 32'(sat_count), m_sat);
    chk("err_drop", 32'(err_drop), 32'(m_err));
    if (q.size() != 0) chk("m_data", 32'(m_data), 32'(q[0]));
    @(posedge clk);
    full = q.size() == 16;
    w = s_valid && !full;
    r = m_ready && q.size() != 0;
    if (s_valid && full) m_err = 1;
    if (r) void'(q.pop_front());
    if (w) begin
      q.push_back(to_q412(s_data));
      if (s_data >= 32'h2000_0000 && m_sat < 65535) m_sat++;
    end
    #1;
  endtask
  task automatic model_reset();
    q.delete();
    m_sat = 0;
    m_err = 0;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_s_ready", 32'(s_ready), 1);
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_sat", 32'(sat_count), 0);
    chk("rst_err", 32'(err_drop), 0);
    reset = 0;
    // single 1.0 sample
    s_valid = 1; s_data = 32'h0200_0000;
    cyc();
    s_valid = 0;
    chk("t1_m_valid", 32'(m_valid), 1);
    chk("t1_m_data", 32'(m_data), 32'h1000);
    cyc();
    chk("t1_level", 32'(level), 1);
    m_ready = 1;
    cyc();
    m_ready = 0;
    chk("t1_level0", 32'(level), 0);
    // saturation
    s_valid = 1; s_data = 32'h2000_0000;
    cyc();
    chk("t2_m_data", 32'(m_data), 32'hFFFF);
    chk("t2_sat", 32'(sat_count), 1);
    s_data = 32'h1FFF_FFFF;
    cyc();
    s_valid = 0;
    chk("t2_sat_stay", 32'(sat_count), 1);
    m_ready = 1;
    cyc();
    chk("t2_m_data2", 32'(m_data), 32'hFFFF);
    cyc();
    m_ready = 0;
    // fill to full
    for (int i = 1; i <= 16; i++) begin
      s_valid = 1; s_data = 32'(i) << 13;
      cyc();
    end
    chk("t3_s_ready", 32'(s_ready), 0);
    chk("t3_level", 32'(level), 16);
    s_data = 32'h0012_3456;
    cyc();
    chk("t3_err", 32'(err_drop), 1);
    chk("t3_level_hold", 32'(level), 16);
    chk("t3_head", 32'(m_data), 1);
    // full with concurrent read and write, through pointer wrap
    m_ready = 1; s_data = 32'(100) << 13;
    cyc();
    chk("t4_no_wr", 32'(level), 15);
    for (int i = 0; i < 24; i++) begin
      s_data = 32'(101 + i) << 13;
      cyc();
      chk("t4_steady", 32'(level), 15);
    end
    s_valid = 0;
    repeat (16) cyc();
    m_ready = 0;
    // async reset with level 7
    for (int i = 0; i < 7; i++) begin
      s_valid = 1; s_data = 32'(i + 3) << 13;
      cyc();
    end
    s_valid = 0;
    chk("t5_level7", 32'(level), 7);
    reset = 1;
    #1;
    chk("t5_m_valid", 32'(m_valid), 0);
    chk("t5_level", 32'(level), 0);
    chk("t5_s_ready", 32'(s_ready), 1);
    chk("t5_sat", 32'(sat_count), 0);
    chk("t5_err", 32'(err_drop), 0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 0;
    s_valid = 1; s_data = 32'h0400_0000;
    cyc();
    s_valid = 0;
    chk("t5_after", 32'(m_data), 32'h2000);
    // random traffic
    for (int i = 0; i < 10000; i++) begin
      s_valid = ($urandom_range(0, 3) != 0);
      m_ready = ($urandom_range(0, 2) != 0);
      s_data = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom >> 3);
      if (i >= 4000 && i < 4300) m_ready = 0;
      cyc();
    end
    s_valid = 0; m_ready = 1;
    repeat (20) cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
